// File: rtl/alu4_result_stage.sv
// Result stage behind a 4-op ALU slice: computes {N,Z,C,V} at push time and
// buffers result+flags in a 2-entry FIFO, with sticky carry/overflow and a result counter.
module alu4_result_stage #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_res,
    input  logic [1:0]   in_op,
    input  logic         in_cout,
    input  logic         in_ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic [3:0]   out_flags,
    output logic [1:0]   sticky_cv,
    output logic [7:0]   res_count
);

    logic [W-1:0] r_res_mem  [2];
    logic [3:0]   r_flag_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic [1:0]   r_sticky;
    logic [7:0]   r_res_count;
    logic         r_alive;

    logic         w_push;
    logic         w_pop;
    logic [3:0]   w_flags;
    logic         w_arith;

    // r_alive holds in_ready low during reset and until the first edge after release.
    assign in_ready  = r_alive && (r_count != 2'd2) && !clr;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !clr;

    assign w_arith   = in_op[1];
    assign w_flags   = {in_res[W-1], (in_res == '0), w_arith & in_cout, w_arith & in_ovf};

    assign out_res   = out_valid ? r_res_mem[r_rptr]  : '0;
    assign out_flags = out_valid ? r_flag_mem[r_rptr] : 4'd0;
    assign sticky_cv = r_sticky;
    assign res_count = r_res_count;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_res_mem[r_wptr]  <= in_res;
            r_flag_mem[r_wptr] <= w_flags;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_sticky    <= 2'd0;
            r_res_count <= 8'd0;
            r_alive     <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (clr) begin
                r_wptr      <= 1'b0;
                r_rptr      <= 1'b0;
                r_count     <= 2'd0;
                r_sticky    <= 2'd0;
                r_res_count <= 8'd0;
            end else begin
                if (w_push) begin
                    r_wptr      <= ~r_wptr;
                    r_sticky    <= r_sticky | w_flags[1:0];
                    r_res_count <= r_res_count + 8'd1;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu4_result_stage.sv
// Bench for alu4_result_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu4_result_stage;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_res;
    logic [1:0]   in_op;
    logic         in_cout;
    logic         in_ovf;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic [3:0]   out_flags;
    logic [1:0]   sticky_cv;
    logic [7:0]   res_count;

    int checks   = 0;
    int failures = 0;

    alu4_result_stage #(.W(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_op     (in_op),
        .in_cout   (in_cout),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags),
        .sticky_cv (sticky_cv),
        .res_count (res_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flags;
    } entry_t;

    entry_t     m_q[$];
    logic [1:0] m_sticky = 2'd0;
    int         m_cnt    = 0;
    bit         m_alive  = 1'b0;
    bit         m_rdy;
    bit         m_push;
    bit         m_pop;
    entry_t     m_e;

    function automatic logic [3:0] ref_flags(logic [W-1:0] res, logic [1:0] op,
                                             logic cout, logic ovf);
        bit n, z, c, v;
        n = ($signed(res) < 0);
        z = (res == 0);
        c = (op == 2'b10 || op == 2'b11) ? cout : 1'b0;
        v = (op == 2'b10 || op == 2'b11) ? ovf  : 1'b0;
        return {n, z, c, v};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge reset_n) begin
        m_q.delete();
        m_sticky = 2'd0;
        m_cnt    = 0;
        m_alive  = 1'b0;
    end

    always @(posedge clock) begin
        if (reset_n) begin
            m_rdy  = m_alive && (m_q.size() < 2) && !clr;
            m_push = in_valid && m_rdy;
            m_pop  = (m_q.size() > 0) && out_ready;
            if (clr) begin
                m_q.delete();
                m_sticky = 2'd0;
                m_cnt    = 0;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) begin
                    m_e.res   = in_res;
                    m_e.flags = ref_flags(in_res, in_op, in_cout, in_ovf);
                    m_q.push_back(m_e);
                    m_sticky = m_sticky | m_e.flags[1:0];
                    m_cnt    = (m_cnt + 1) % 256;
                end
            end
            m_alive = 1'b1;
        end
    end

    // Mid-cycle comparison of every output against the model.
    always @(negedge clock) begin
        chk("m_in_ready",  {31'd0, in_ready},  {31'd0, (m_alive && m_q.size() < 2 && !clr && reset_n)});
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
        chk("m_out_res",   {28'd0, out_res},   (m_q.size() > 0) ? {28'd0, m_q[0].res}   : 32'd0);
        chk("m_out_flags", {28'd0, out_flags}, (m_q.size() > 0) ? {28'd0, m_q[0].flags} : 32'd0);
        chk("m_sticky",    {30'd0, sticky_cv}, {30'd0, m_sticky});
        chk("m_count",     {24'd0, res_count}, m_cnt);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic v, logic [1:0] op, logic [W-1:0] res, logic c, logic o);
        in_valid = v;
        in_op    = op;
        in_res   = res;
        in_cout  = c;
        in_ovf   = o;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_res",   {28'd0, out_res},   32'd0);
        chk("rst_count",     {24'd0, res_count}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

        // Scenario 1: OR of zero
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        chk("s1_valid", {31'd0, out_valid}, 32'd1);
        chk("s1_res",   {28'd0, out_res},   32'd0);
        chk("s1_flags", {28'd0, out_flags}, 32'b0100);
        chk("s1_count", {24'd0, res_count}, 32'd1);
        tick();

        // Scenario 2: ADD with carry and overflow, then AND
        drive(1'b1, 2'b10, 4'b1000, 1'b1, 1'b1);
        tick();
        chk("s2_flags",  {28'd0, out_flags}, 32'b1011);
        chk("s2_sticky", {30'd0, sticky_cv}, 32'b11);
        drive(1'b1, 2'b00, 4'b0011, 1'b1, 1'b1);
        tick();
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        chk("s2_and_flags",  {28'd0, out_flags}, 32'b0000);
        chk("s2_and_sticky", {30'd0, sticky_cv}, 32'b11);
        tick();
        do_clr();

        // Scenario 3: back-pressure with three back-to-back pushes
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 4'd1, 1'b0, 1'b0);
        tick();
        in_res = 4'd2;
        tick();
        in_res = 4'd3;
        chk("s3_ready_full", {31'd0, in_ready}, 32'd0);
        tick();
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        chk("s3_count", {24'd0, res_count}, 32'd2);
        out_ready = 1'b1;
        chk("s3_first", {28'd0, out_res}, 32'd1);
        tick();
        chk("s3_second", {28'd0, out_res}, 32'd2);
        tick();
        chk("s3_empty", {31'd0, out_valid}, 32'd0);
        do_clr();

        // Scenario 4: streaming at occupancy 1
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 4'd0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_res = 4'(i);
            tick();
            chk("s4_head",  {28'd0, out_res},   i % 16);
            chk("s4_ready", {31'd0, in_ready},  32'd1);
        end
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        chk("s4_count", {24'd0, res_count}, 32'd11);
        tick();
        do_clr();

        // Scenario 5: counter wrap, then clr beats a push
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        chk("s5_wrap", {24'd0, res_count}, 32'd0);
        clr = 1'b1;
        drive(1'b1, 2'b10, 4'd5, 1'b1, 1'b1);
        tick();
        clr = 1'b0;
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        chk("s5_clr_valid",  {31'd0, out_valid}, 32'd0);
        chk("s5_clr_sticky", {30'd0, sticky_cv}, 32'd0);
        chk("s5_clr_count",  {24'd0, res_count}, 32'd0);

        // Randomized traffic with occasional clear
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  4'($urandom), 1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 31) == 0);
            tick();
        end
        clr = 1'b0;

        // Scenario 6: asynchronous reset while full
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 4'd9, 1'b1, 1'b0);
        tick();
        tick();
        drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
        chk("s6_full", {31'd0, in_ready}, 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("s6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_rst_count", {24'd0, res_count}, 32'd0);
        chk("s6_rst_ready", {31'd0, in_ready},  32'd0);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("s6_no_stale", {31'd0, out_valid}, 32'd0);
        tick();
        chk("s6_after_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_after_ready", {31'd0, in_ready},  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
